// File: rtl/tile_frame_buffer_pkg.sv
// tile_frame_buffer_pkg: state encoding, command priority and geometry helpers
package tile_frame_buffer_pkg;
  typedef enum logic [2:0] {IDLE, COMMIT_INIT, COMMIT, MEMSET, LOAD} state_e;
  function automatic int pixel_per_beat(int stream_width, int pixel_width);
    return stream_width / pixel_width;
  endfunction
  function automatic int mem_addr_width(int max_frame_size, int ppb);
    return $clog2(max_frame_size) - $clog2(ppb);
  endfunction
  function automatic int lane_bits(int ppb);
    return ppb > 1 ? $clog2(ppb) : 1;
  endfunction
  function automatic state_e cmd_next_state(logic commit, logic load, logic memset);
    return commit ? COMMIT_INIT : load ? LOAD : memset ? MEMSET : IDLE;
  endfunction
endpackage

// File: rtl/tile_frame_buffer_if.sv
// tile_frame_buffer_if: commit (m_axis) and load (s_axis) AXI-Stream bundle
interface tile_frame_buffer_if #(parameter int STREAM_WIDTH = 16);
  logic m_axis_tvalid, m_axis_tready, m_axis_tlast;
  logic [STREAM_WIDTH-1:0] m_axis_tdata;
  logic s_axis_tvalid, s_axis_tready, s_axis_tlast;
  logic [STREAM_WIDTH-1:0] s_axis_tdata;
  modport master (
    output m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready,
    input m_axis_tready, s_axis_tvalid, s_axis_tlast, s_axis_tdata
  );
  modport slave (
    input m_axis_tvalid, m_axis_tlast, m_axis_tdata, s_axis_tready,
    output m_axis_tready, s_axis_tvalid, s_axis_tlast, s_axis_tdata
  );
endinterface

// File: rtl/tile_frame_buffer_ram.sv
// tile_frame_buffer_ram: strobed simple-dual-port RAM with registered read
module tile_frame_buffer_ram #(
  parameter int ADDR_WIDTH = 13,
  parameter int DATA_WIDTH = 16,
  parameter int STRB_WIDTH = 4
) (
  input  logic                  clk,
  input  logic                  we_i,
  input  logic [ADDR_WIDTH-1:0] waddr_i,
  input  logic [DATA_WIDTH-1:0] wdata_i,
  input  logic [STRB_WIDTH-1:0] wstrb_i,
  input  logic [ADDR_WIDTH-1:0] raddr_i,
  output logic [DATA_WIDTH-1:0] rdata_o
);
  localparam int LW = DATA_WIDTH / STRB_WIDTH;
  logic [DATA_WIDTH-1:0] mem_q [2**ADDR_WIDTH];
  logic [DATA_WIDTH-1:0] rdata_q;
  always_ff @(posedge clk) begin
    for (int i = 0; i < STRB_WIDTH; i++)
      if (we_i && wstrb_i[i]) mem_q[waddr_i][i*LW +: LW] <= wdata_i[i*LW +: LW];
    rdata_q <= mem_q[raddr_i];
  end
  assign rdata_o = rdata_q;
endmodule

// File: rtl/tile_frame_buffer.sv
// tile_frame_buffer: tile RAM with fragment access, commit stream, memset and load (TILE_FRAME_BUFFER_LOAD_EN)
module tile_frame_buffer
  import tile_frame_buffer_pkg::*;
#(
  parameter int MAX_FRAME_SIZE = 128*128,
  parameter int NUMBER_OF_SUB_PIXELS = 4,
  parameter int SUB_PIXEL_WIDTH = 4,
  parameter int STREAM_WIDTH = 16,
  localparam int PIXEL_WIDTH = NUMBER_OF_SUB_PIXELS * SUB_PIXEL_WIDTH,
  localparam int PPB = pixel_per_beat(STREAM_WIDTH, PIXEL_WIDTH),
  localparam int ADDR_WIDTH = $clog2(MAX_FRAME_SIZE),
  localparam int MEM_ADDR_WIDTH = mem_addr_width(MAX_FRAME_SIZE, PPB)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [ADDR_WIDTH-1:0]     fragIndexRead,
  output logic [PIXEL_WIDTH-1:0]    fragOut,
  input  logic [ADDR_WIDTH-1:0]     fragIndexWrite,
  input  logic [PIXEL_WIDTH-1:0]    fragIn,
  input  logic                      fragWriteEnable,
  input  logic [NUMBER_OF_SUB_PIXELS-1:0] fragMask,
  input  logic [MEM_ADDR_WIDTH:0]   frameSizeBeats,
  input  logic                      apply,
  output logic                      applied,
  input  logic                      cmdCommit,
  input  logic                      cmdMemset,
  input  logic                      cmdLoad,
  input  logic [PIXEL_WIDTH-1:0]    clearColor,
  tile_frame_buffer_if.master       axis
);
  localparam int SZW = MEM_ADDR_WIDTH + 1;
  localparam int LB = lane_bits(PPB);
  localparam int STRB_WIDTH = PPB * NUMBER_OF_SUB_PIXELS;
  localparam logic [SZW-1:0] MAX_BEATS = SZW'(MAX_FRAME_SIZE / PPB);
  state_e state_q;
  logic [SZW-1:0] size_q, cnt_q, size_in;
  logic applied_q, tvalid_q, tlast_q, cmd_load_q, cmd_memset_q;
  logic [LB-1:0] lane_q;
  logic we, m_hs, s_hs, last, load_sel;
  logic [MEM_ADDR_WIDTH-1:0] waddr, raddr;
  logic [STREAM_WIDTH-1:0] wdata, rdata;
  logic [STRB_WIDTH-1:0] wstrb;
`ifdef TILE_FRAME_BUFFER_LOAD_EN
  assign load_sel = cmdLoad;
  assign axis.s_axis_tready = state_q == LOAD;
`else
  logic unused_ok;
  assign load_sel = 1'b0;
  assign axis.s_axis_tready = 1'b0;
  assign unused_ok = ^{cmdLoad, axis.s_axis_tlast};
`endif
  always_comb begin
    size_in = frameSizeBeats > MAX_BEATS ? MAX_BEATS : frameSizeBeats;
    last = cnt_q == size_q - 1'b1;
    m_hs = tvalid_q && axis.m_axis_tready;
    s_hs = state_q == LOAD && axis.s_axis_tvalid;
    we = (state_q == IDLE && applied_q && fragWriteEnable) || state_q == MEMSET || s_hs;
    waddr = state_q == IDLE ? MEM_ADDR_WIDTH'(fragIndexWrite / PPB) : cnt_q[MEM_ADDR_WIDTH-1:0];
    wdata = state_q == MEMSET ? {PPB{clearColor}} : state_q == LOAD ? axis.s_axis_tdata : {PPB{fragIn}};
    wstrb = state_q == MEMSET ? {PPB{fragMask}} : state_q == LOAD ? '1 :
            STRB_WIDTH'(fragMask) << (NUMBER_OF_SUB_PIXELS * (fragIndexWrite % PPB));
    // Look ahead on a handshake so the next beat is ready one cycle later
    raddr = state_q == IDLE ? MEM_ADDR_WIDTH'(fragIndexRead / PPB)
                            : cnt_q[MEM_ADDR_WIDTH-1:0] + MEM_ADDR_WIDTH'(m_hs);
  end
  tile_frame_buffer_ram #(
    .ADDR_WIDTH(MEM_ADDR_WIDTH), .DATA_WIDTH(STREAM_WIDTH), .STRB_WIDTH(STRB_WIDTH)
  ) u_ram (
    .clk(clk), .we_i(we), .waddr_i(waddr), .wdata_i(wdata), .wstrb_i(wstrb),
    .raddr_i(raddr), .rdata_o(rdata)
  );
  always_ff @(posedge clk) lane_q <= LB'(fragIndexRead % PPB);
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      applied_q <= 1'b1;
      tvalid_q <= 1'b0;
      tlast_q <= 1'b0;
      cnt_q <= '0;
      size_q <= '0;
      cmd_load_q <= 1'b0;
      cmd_memset_q <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          applied_q <= !apply;
          cnt_q <= '0;
          if (apply) begin
            size_q <= size_in;
            cmd_load_q <= load_sel;
            cmd_memset_q <= cmdMemset;
            if (size_in != '0) state_q <= cmd_next_state(cmdCommit, load_sel, cmdMemset);
          end
        end
        COMMIT_INIT: begin
          state_q <= COMMIT;
          tvalid_q <= 1'b1;
          tlast_q <= size_q == SZW'(1);
        end
        COMMIT: if (m_hs) begin
          if (last) begin
            tvalid_q <= 1'b0;
            tlast_q <= 1'b0;
            cnt_q <= '0;
            state_q <= cmd_load_q ? LOAD : cmd_memset_q ? MEMSET : IDLE;
            applied_q <= !cmd_load_q && !cmd_memset_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            tlast_q <= cnt_q + SZW'(2) == size_q;
          end
        end
        MEMSET: begin
          cnt_q <= last ? '0 : cnt_q + 1'b1;
          if (last) begin
            state_q <= IDLE;
            applied_q <= 1'b1;
          end
        end
`ifdef TILE_FRAME_BUFFER_LOAD_EN
        LOAD: if (s_hs) begin
          cnt_q <= last || axis.s_axis_tlast ? '0 : cnt_q + 1'b1;
          if (last || axis.s_axis_tlast) begin
            state_q <= IDLE;
            applied_q <= 1'b1;
          end
        end
`endif
        default: state_q <= IDLE;
      endcase
    end
  end
  assign fragOut = rdata[lane_q*PIXEL_WIDTH +: PIXEL_WIDTH];
  assign applied = applied_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tlast = tlast_q;
  assign axis.m_axis_tdata = rdata;
endmodule

// File: tb/tb_tile_frame_buffer.sv
// tb_tile_frame_buffer: randomized self-checking bench against a pixel-array reference model
module tb_tile_frame_buffer;
  localparam int MAXF = 256;
  localparam int NSP = 4;
  localparam int SPW = 4;
  localparam int SW = 32;
  localparam int PW = NSP * SPW;
  localparam int PPB = SW / PW;
  localparam int AW = 8;
  localparam int MAW = 7;
  localparam int BEATS = MAXF / PPB;
  logic clk = 1'b0;
  logic reset;
  logic [AW-1:0] fragIndexRead, fragIndexWrite;
  logic [PW-1:0] fragOut, fragIn, clearColor;
  logic fragWriteEnable, apply, applied, cmdCommit, cmdMemset, cmdLoad;
  logic [NSP-1:0] fragMask;
  logic [MAW:0] frameSizeBeats;
  int cmp_cnt = 0;
  int err_cnt = 0;
  logic [PW-1:0] model [MAXF];
  tile_frame_buffer_if #(.STREAM_WIDTH(SW)) axis();
  tile_frame_buffer #(
    .MAX_FRAME_SIZE(MAXF), .NUMBER_OF_SUB_PIXELS(NSP), .SUB_PIXEL_WIDTH(SPW), .STREAM_WIDTH(SW)
  ) dut (
    .clk(clk), .reset(reset), .fragIndexRead(fragIndexRead), .fragOut(fragOut),
    .fragIndexWrite(fragIndexWrite), .fragIn(fragIn), .fragWriteEnable(fragWriteEnable),
    .fragMask(fragMask), .frameSizeBeats(frameSizeBeats), .apply(apply), .applied(applied),
    .cmdCommit(cmdCommit), .cmdMemset(cmdMemset), .cmdLoad(cmdLoad), .clearColor(clearColor),
    .axis(axis.master)
  );
  always #5 clk = ~clk;
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [SW-1:0] beat(int b);
    logic [SW-1:0] r;
    for (int p = 0; p < PPB; p++) r[p*PW +: PW] = model[b*PPB + p];
    return r;
  endfunction
  task automatic model_clear(input int n, input logic [PW-1:0] color, input logic [NSP-1:0] mask);
    for (int b = 0; b < n; b++)
      for (int p = 0; p < PPB; p++)
        for (int c = 0; c < NSP; c++)
          if (mask[c]) model[b*PPB + p][c*SPW +: SPW] = color[c*SPW +: SPW];
  endtask
  task automatic apply_cmd(input int size, input bit c, input bit m, input bit l);
    frameSizeBeats = (MAW+1)'(size);
    cmdCommit = c;
    cmdMemset = m;
    cmdLoad = l;
    apply = 1'b1;
    cyc();
    apply = 1'b0;
    cmdCommit = 1'b0;
    cmdMemset = 1'b0;
    cmdLoad = 1'b0;
  endtask
  task automatic frag_write(input int idx, input logic [PW-1:0] d, input logic [NSP-1:0] m);
    fragIndexWrite = AW'(idx);
    fragIn = d;
    fragMask = m;
    fragWriteEnable = 1'b1;
    cyc();
    fragWriteEnable = 1'b0;
    for (int c = 0; c < NSP; c++) if (m[c]) model[idx][c*SPW +: SPW] = d[c*SPW +: SPW];
  endtask
  task automatic check_pixels(input int from, input int to);
    for (int i = from; i < to; i++) begin
      fragIndexRead = AW'(i);
      cyc();
      cmp_cnt++;
      if (fragOut !== model[i]) begin
        err_cnt++;
        $display("FAIL pixel[%0d]: got %h expected %h", i, fragOut, model[i]);
      end
    end
  endtask
  task automatic run_memset(input int size, input logic [PW-1:0] color, input logic [NSP-1:0] mask);
    int n, lim;
    lim = size > BEATS ? BEATS : size;
    clearColor = color;
    fragMask = mask;
    apply_cmd(size, 0, 1, 0);
    n = 0;
    while (applied !== 1'b1 && n < 1000) begin
      cyc();
      n++;
    end
    cmp_cnt++;
    if (n != lim) begin
      err_cnt++;
      $display("FAIL memset_cycles size=%0d: got %0d expected %0d", size, n, lim);
    end
    model_clear(lim, color, mask);
  endtask
  task automatic run_commit(input int size, input bit rnd, input bit mem);
    int pat[4] = '{1, 0, 0, 1};
    logic [SW-1:0] held;
    bit stalled, rdy;
    int got, n, k, lim;
    lim = size > BEATS ? BEATS : size;
    apply_cmd(size, 1, mem, 0);
    got = 0;
    n = 0;
    k = 0;
    stalled = 0;
    while (got < lim && n < 2000) begin
      if (stalled) begin
        cmp_cnt++;
        if (axis.m_axis_tvalid !== 1'b1 || axis.m_axis_tdata !== held) begin
          err_cnt++;
          $display("FAIL commit_stall beat %0d: valid %b data %h expected data %h", got, axis.m_axis_tvalid, axis.m_axis_tdata, held);
        end
      end
      stalled = 0;
      rdy = rnd ? bit'($urandom_range(0, 1)) : bit'(pat[k % 4]);
      axis.m_axis_tready = rdy;
      if (axis.m_axis_tvalid === 1'b1) begin
        k++;
        cmp_cnt++;
        if (axis.m_axis_tlast !== (got == lim - 1)) begin
          err_cnt++;
          $display("FAIL commit_tlast beat %0d: got %b expected %b", got, axis.m_axis_tlast, got == lim - 1);
        end
        if (rdy) begin
          cmp_cnt++;
          if (axis.m_axis_tdata !== beat(got)) begin
            err_cnt++;
            $display("FAIL commit_data beat %0d: got %h expected %h", got, axis.m_axis_tdata, beat(got));
          end
          got++;
        end else begin
          held = axis.m_axis_tdata;
          stalled = 1;
        end
      end
      cyc();
      n++;
    end
    axis.m_axis_tready = 1'b0;
    cmp_cnt++;
    if (got != lim || axis.m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL commit_end: beats %0d expected %0d, tvalid %b expected 0", got, lim, axis.m_axis_tvalid);
    end
    if (!mem) begin
      cmp_cnt++;
      if (applied !== 1'b1) begin
        err_cnt++;
        $display("FAIL commit_applied: got %b expected 1", applied);
      end
    end
  endtask
  task automatic test_reset;
    reset = 1'b1;
    cyc();
    cyc();
    cmp_cnt++;
    if (applied !== 1'b1 || axis.m_axis_tvalid !== 1'b0 || axis.m_axis_tlast !== 1'b0 || axis.s_axis_tready !== 1'b0) begin
      err_cnt++;
      $display("FAIL reset_state: applied %b tvalid %b tlast %b s_tready %b expected 1 0 0 0",
               applied, axis.m_axis_tvalid, axis.m_axis_tlast, axis.s_axis_tready);
    end
    reset = 1'b0;
    cyc();
  endtask
  task automatic test_clear_full;
    run_memset(255, PW'($urandom), 4'hF);
    check_pixels(0, MAXF);
  endtask
  task automatic test_memset;
    run_memset(8, 16'h1234, 4'hF);
    check_pixels(0, 16);
    cmp_cnt++;
    if (model[15] !== 16'h1234) begin
      err_cnt++;
      $display("FAIL memset_model: got %h expected 1234", model[15]);
    end
    run_memset($urandom_range(1, 20), PW'($urandom), NSP'($urandom));
    check_pixels(0, 48);
  endtask
  task automatic test_idle_access;
    frag_write(5, 16'hABCD, 4'hF);
    fragIndexRead = AW'(5);
    cyc();
    cmp_cnt++;
    if (fragOut !== 16'hABCD) begin
      err_cnt++;
      $display("FAIL idle_read5: got %h expected abcd", fragOut);
    end
    frag_write(5, PW'($urandom), 4'h3);
    check_pixels(5, 6);
    for (int i = 0; i < 24; i++) begin
      frag_write($urandom_range(0, MAXF - 1), PW'($urandom), NSP'($urandom));
      check_pixels($urandom_range(0, MAXF - 1), 0);
    end
    check_pixels(0, 64);
  endtask
  task automatic test_commit_backpressure;
    run_commit(4, 0, 0);
    run_commit(1, 1, 0);
    run_commit($urandom_range(2, 40), 1, 0);
    run_commit(255, 1, 0);
  endtask
  task automatic test_commit_memset;
    int n;
    clearColor = PW'($urandom);
    fragMask = 4'hF;
    run_commit(4, 1, 1);
    n = 0;
    while (applied !== 1'b1 && n < 100) begin
      cyc();
      n++;
    end
    cmp_cnt++;
    if (n != 4) begin
      err_cnt++;
      $display("FAIL commit_memset_cycles: got %0d expected 4", n);
    end
    model_clear(4, clearColor, 4'hF);
    run_commit(4, 1, 0);
    check_pixels(0, 10);
  endtask
  task automatic load_run(input int size, input int nsend);
    logic [SW-1:0] d;
    bit v, rdy;
    int sent, n;
    apply_cmd(size, 0, 0, 1);
    cmp_cnt++;
    if (axis.s_axis_tready !== 1'b1 || applied !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_start: s_tready %b applied %b expected 1 0", axis.s_axis_tready, applied);
    end
    sent = 0;
    n = 0;
    while (sent < nsend && n < 500) begin
      v = $urandom_range(0, 3) != 0;
      d = SW'($urandom);
      axis.s_axis_tvalid = v;
      axis.s_axis_tdata = d;
      axis.s_axis_tlast = v && sent == nsend - 1 && nsend < size;
      rdy = axis.s_axis_tready;
      cyc();
      n++;
      if (v && rdy) begin
        for (int p = 0; p < PPB; p++) model[sent*PPB + p] = d[p*PW +: PW];
        sent++;
      end
    end
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast = 1'b0;
    cmp_cnt++;
    if (sent != nsend || applied !== 1'b1 || axis.s_axis_tready !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_end: sent %0d applied %b s_tready %b expected %0d 1 0", sent, applied, axis.s_axis_tready, nsend);
    end
  endtask
  task automatic test_load;
`ifdef TILE_FRAME_BUFFER_LOAD_EN
    load_run(8, 3);
    run_commit(8, 1, 0);
    load_run(5, 5);
    check_pixels(0, 20);
`else
    axis.s_axis_tvalid = 1'b1;
    axis.s_axis_tdata = SW'($urandom);
    apply_cmd(4, 0, 0, 1);
    cmp_cnt++;
    if (axis.s_axis_tready !== 1'b0 || applied !== 1'b0) begin
      err_cnt++;
      $display("FAIL load_disabled_start: s_tready %b applied %b expected 0 0", axis.s_axis_tready, applied);
    end
    cyc();
    axis.s_axis_tvalid = 1'b0;
    cmp_cnt++;
    if (axis.s_axis_tready !== 1'b0 || applied !== 1'b1) begin
      err_cnt++;
      $display("FAIL load_disabled_end: s_tready %b applied %b expected 0 1", axis.s_axis_tready, applied);
    end
    check_pixels(0, 8);
`endif
  endtask
  task automatic test_size_zero;
    apply_cmd(0, 1, 0, 0);
    cmp_cnt++;
    if (applied !== 1'b0 || axis.m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL size0_first: applied %b tvalid %b expected 0 0", applied, axis.m_axis_tvalid);
    end
    fragIndexWrite = AW'(7);
    fragIn = ~model[7];
    fragMask = 4'hF;
    fragWriteEnable = 1'b1;
    cyc();
    fragWriteEnable = 1'b0;
    cmp_cnt++;
    if (applied !== 1'b1 || axis.m_axis_tvalid !== 1'b0) begin
      err_cnt++;
      $display("FAIL size0_second: applied %b tvalid %b expected 1 0", applied, axis.m_axis_tvalid);
    end
    check_pixels(7, 8);
  endtask
  task automatic test_reset_mid_commit;
    axis.m_axis_tready = 1'b0;
    apply_cmd(8, 1, 0, 0);
    cyc();
    cyc();
    cmp_cnt++;
    if (axis.m_axis_tvalid !== 1'b1 || applied !== 1'b0) begin
      err_cnt++;
      $display("FAIL midcommit_active: tvalid %b applied %b expected 1 0", axis.m_axis_tvalid, applied);
    end
    reset = 1'b1;
    cyc();
    cmp_cnt++;
    if (axis.m_axis_tvalid !== 1'b0 || applied !== 1'b1 || axis.m_axis_tlast !== 1'b0) begin
      err_cnt++;
      $display("FAIL midcommit_reset: tvalid %b applied %b tlast %b expected 0 1 0", axis.m_axis_tvalid, applied, axis.m_axis_tlast);
    end
    reset = 1'b0;
    cyc();
    cmp_cnt++;
    if (axis.m_axis_tvalid !== 1'b0 || applied !== 1'b1) begin
      err_cnt++;
      $display("FAIL midcommit_after: tvalid %b applied %b expected 0 1", axis.m_axis_tvalid, applied);
    end
  endtask
  initial begin
    reset = 1'b1;
    apply = 1'b0;
    cmdCommit = 1'b0;
    cmdMemset = 1'b0;
    cmdLoad = 1'b0;
    fragWriteEnable = 1'b0;
    fragIndexRead = '0;
    fragIndexWrite = '0;
    fragIn = '0;
    fragMask = 4'hF;
    clearColor = '0;
    frameSizeBeats = '0;
    axis.m_axis_tready = 1'b0;
    axis.s_axis_tvalid = 1'b0;
    axis.s_axis_tlast = 1'b0;
    axis.s_axis_tdata = '0;
    test_reset();
    test_clear_full();
    test_memset();
    test_idle_access();
    test_commit_backpressure();
    test_commit_memset();
    test_load();
    test_size_zero();
    test_reset_mid_commit();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
    $finish;
  end
endmodule
